serial_mag_comparator: RTL and testbench

- Parametrised, bit-serial, MSB-first magnitude comparator for two WIDTH-bit operands.
- Supports unsigned or two's-complement signed mode, selected per operation.
- Uses a start/busy/done handshake and can optionally terminate early at the first differing bit.
- Successor to the team's 2-bit combinational comparator, for use wherever wide operands must be compared with minimal logic.

---
 rtl/serial_mag_comparator.sv | 165 ++++++++++++++++
 tb/tb_serial_mag_comparator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial, MSB-first magnitude comparator for two WIDTH-bit operands,
//   unsigned or two's-complement per operation.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     start        request a comparison (sampled only while idle)
//     signed_mode  0 = unsigned, 1 = two's-complement (latched with start)
//     a, b         operands (latched with start)
//     busy         high while a comparison is in flight
//     done         one-cycle pulse; result outputs valid from this cycle on
//     a_lt_b       A < B  (registered, held until the next result)
//     a_gt_b       A > B
//     a_eq_b       A == B
//
//   Parameters:
//     WIDTH       operand width, >= 2
//     EARLY_EXIT  1 = finish at the first differing bit,
//                 0 = always scan all WIDTH bits (fixed latency)
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  // First-difference record: found flag and its verdict (1 = A greater).
  logic             diff_found_q, diff_found_d;
  logic             diff_gt_q, diff_gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  // Per-bit evaluation of the currently indexed bit pair.
  logic bit_a, bit_b, bit_differ, bit_gt;
  logic found_now, gt_now, finish;

  always_comb begin
    bit_a      = a_q[idx_q];
    bit_b      = b_q[idx_q];
    bit_differ = bit_a ^ bit_b;
    // On the sign bit of a signed operand a set bit means "more negative",
    // so the verdict inverts: A is greater exactly when B holds the 1.
    bit_gt     = (sgn_q && (idx_q == TOP_IDX)) ? bit_b : bit_a;

    // Only the first difference counts; later bits never override it.
    found_now  = diff_found_q | bit_differ;
    gt_now     = diff_found_q ? diff_gt_q : bit_gt;

    finish     = (idx_q == '0) || ((EARLY_EXIT != 0) && bit_differ);
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sgn_d        = sgn_q;
    idx_d        = idx_q;
    diff_found_d = diff_found_q;
    diff_gt_d    = diff_gt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lt_d         = lt_q;
    gt_d         = gt_q;
    eq_d         = eq_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d          = a;
          b_d          = b;
          sgn_d        = signed_mode;
          idx_d        = TOP_IDX;
          diff_found_d = 1'b0;
          diff_gt_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = COMPARE;
        end
      end

      COMPARE: begin
        if (finish) begin
          lt_d    = found_now & ~gt_now;
          gt_d    = found_now &  gt_now;
          eq_d    = ~found_now;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d        = idx_q - IW'(1);
          diff_found_d = found_now;
          diff_gt_d    = gt_now;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sgn_q        <= 1'b0;
      idx_q        <= '0;
      diff_found_q <= 1'b0;
      diff_gt_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lt_q         <= 1'b0;
      gt_q         <= 1'b0;
      eq_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sgn_q        <= sgn_d;
      idx_q        <= idx_d;
      diff_found_q <= diff_found_d;
      diff_gt_q    <= diff_gt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
      eq_q         <= eq_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_lt_b = lt_q;
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator (WIDTH=8). Two instances share the same
// stimulus: one with early exit, one with fixed latency.
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sm = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;

  logic busy_e, done_e, lt_e, gt_e, eq_e;
  logic busy_f, done_f, lt_f, gt_f, eq_f;

  int total = 0;
  int bad   = 0;

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a_i), .b(b_i),
    .busy(busy_e), .done(done_e), .a_lt_b(lt_e), .a_gt_b(gt_e), .a_eq_b(eq_e)
  );

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a_i), .b(b_i),
    .busy(busy_f), .done(done_f), .a_lt_b(lt_f), .a_gt_b(gt_f), .a_eq_b(eq_f)
  );

  always #5 clk = ~clk;

  // Reference model: result from plain (signed/unsigned) arithmetic, encoded {lt,gt,eq}.
  function automatic logic [2:0] exp_res(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic smv);
    int sa, sb;
    if (smv) begin
      sa = int'($signed(av));
      sb = int'($signed(bv));
    end else begin
      sa = int'(av);
      sb = int'(bv);
    end
    if (sa < sb) return 3'b100;
    if (sa > sb) return 3'b010;
    return 3'b001;
  endfunction

  // Early-exit latency: WIDTH - (highest differing bit), or WIDTH when equal.
  function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] x;
    x = av ^ bv;
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return W - i;
    return W;
  endfunction

  // Launches one operation and observes both instances for W+2 cycles after E0.
  // Operands are scrambled after E0 to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                        output int le, output int lf,
                        output logic [2:0] re, output logic [2:0] rf,
                        output int nde, output int ndf, output int berr);
    le = -1; lf = -1; re = '0; rf = '0; nde = 0; ndf = 0; berr = 0;
    @(negedge clk);
    a_i = av; b_i = bv; sm = smv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy_e !== 1'b1) berr++;
    if (busy_f !== 1'b1) berr++;
    for (int k = 1; k <= W + 2; k++) begin
      a_i = W'($urandom); b_i = W'($urandom); sm = 1'($urandom);
      @(posedge clk); #1;
      if (done_e === 1'b1) begin
        nde++;
        if (le < 0) begin le = k; re = {lt_e, gt_e, eq_e}; end
      end
      if (done_f === 1'b1) begin
        ndf++;
        if (lf < 0) begin lf = k; rf = {lt_f, gt_f, eq_f}; end
      end
      if (busy_e !== (le < 0)) berr++;
      if (busy_f !== (lf < 0)) berr++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_e !== 1'b0 || busy_f !== 1'b0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy_e !== 1'b0 || busy_f !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout busy_e=%b busy_f=%b required 0/0", name, busy_e, busy_f);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy_e, done_e, lt_e, gt_e, eq_e, busy_f, done_f, lt_f, gt_f, eq_f} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got e=%b%b%b%b%b f=%b%b%b%b%b required all 0",
               busy_e, done_e, lt_e, gt_e, eq_e, busy_f, done_f, lt_f, gt_f, eq_f);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7];
    logic [W-1:0] tb [7];
    logic         ts [7];
    int le, lf, nde, ndf, berr;
    logic [2:0] re, rf, er;
    int el;
    ta = '{8'h5A, 8'h80, 8'h80, 8'hFE, 8'h03, 8'h00, 8'h7F};
    tb = '{8'h5A, 8'h7F, 8'h7F, 8'hFD, 8'h05, 8'hFF, 8'h80};
    ts = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], ts[i], le, lf, re, rf, nde, ndf, berr);
      er = exp_res(ta[i], tb[i], ts[i]);
      el = exp_lat(ta[i], tb[i]);
      total += 7;
      if (le !== el) begin bad++;
        $display("FAIL dir%0d latency_early got=%0d required=%0d", i, le, el); end
      if (lf !== W) begin bad++;
        $display("FAIL dir%0d latency_fixed got=%0d required=%0d", i, lf, W); end
      if (re !== er) begin bad++;
        $display("FAIL dir%0d result_early got=%b required=%b", i, re, er); end
      if (rf !== er) begin bad++;
        $display("FAIL dir%0d result_fixed got=%b required=%b", i, rf, er); end
      if (nde !== 1 || ndf !== 1) begin bad++;
        $display("FAIL dir%0d done_pulses got=%0d/%0d required=1/1", i, nde, ndf); end
      if (berr !== 0) begin bad++;
        $display("FAIL dir%0d busy_profile errors=%0d required=0", i, berr); end
      if ({lt_e, gt_e, eq_e} !== er) begin bad++;
        $display("FAIL dir%0d result_hold got=%b required=%b", i, {lt_e, gt_e, eq_e}, er); end
    end
  endtask

  task automatic test_random();
    int le, lf, nde, ndf, berr;
    logic [2:0] re, rf, er;
    logic [W-1:0] av, bv;
    logic smv;
    int el;
    for (int i = 0; i < 40; i++) begin
      av  = W'($urandom);
      bv  = W'($urandom);
      smv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: bv = av;
        1: bv = av ^ (W'(1) << $urandom_range(0, W - 1));
        default: ;
      endcase
      run_op(av, bv, smv, le, lf, re, rf, nde, ndf, berr);
      er = exp_res(av, bv, smv);
      el = exp_lat(av, bv);
      total++;
      if (le !== el || lf !== W || re !== er || rf !== er ||
          nde !== 1 || ndf !== 1 || berr !== 0) begin
        bad++;
        $display("FAIL rnd%0d a=%h b=%h s=%b got lat=%0d/%0d res=%b/%b dones=%0d/%0d berr=%0d required lat=%0d/%0d res=%b dones=1/1 berr=0",
                 i, av, bv, smv, le, lf, re, rf, nde, ndf, berr, el, W, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2:0] er1, er2;
    wait_idle("b2b_pre");
    er1 = exp_res(8'h10, 8'h20, 1'b0);
    er2 = exp_res(8'hC3, 8'hC3, 1'b0);
    @(negedge clk);
    a_i = 8'h10; b_i = 8'h20; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;                     // E0
    start = 1'b0;
    @(posedge clk); #1;                     // E1
    @(negedge clk);
    a_i = 8'hFF; b_i = 8'h00; start = 1'b1; // ignored: busy
    @(posedge clk); #1;                     // E2
    start = 1'b0;
    total++;
    if (busy_e !== 1'b1 || done_e !== 1'b0) begin bad++;
      $display("FAIL b2b_e2_state busy=%b done=%b required 1/0", busy_e, done_e); end
    @(posedge clk); #1;                     // E3
    total++;
    if (done_e !== 1'b1 || {lt_e, gt_e, eq_e} !== er1) begin bad++;
      $display("FAIL b2b_e3_done done=%b res=%b required 1/%b", done_e, {lt_e, gt_e, eq_e}, er1); end
    a_i = 8'hC3; b_i = 8'hC3; sm = 1'b0; start = 1'b1;  // during the done cycle
    @(posedge clk); #1;                     // E4 = new E0 for early instance
    start = 1'b0;
    total++;
    if (busy_e !== 1'b1 || done_e !== 1'b0 || {lt_e, gt_e, eq_e} !== er1) begin bad++;
      $display("FAIL b2b_accept busy=%b done=%b res=%b required 1/0/%b",
               busy_e, done_e, {lt_e, gt_e, eq_e}, er1); end
    lat = -1;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (done_e === 1'b1 && lat < 0) lat = k;
    end
    total++;
    if (lat !== W || {lt_e, gt_e, eq_e} !== er2) begin bad++;
      $display("FAIL b2b_second lat=%0d res=%b required %0d/%b", lat, {lt_e, gt_e, eq_e}, W, er2); end
    total++;
    if (busy_f !== 1'b0 || {lt_f, gt_f, eq_f} !== er1) begin bad++;
      $display("FAIL b2b_fixed_first busy=%b res=%b required 0/%b", busy_f, {lt_f, gt_f, eq_f}, er1); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int le, lf, nde, ndf, berr;
    logic [2:0] re, rf, er;
    wait_idle("abort_pre");
    @(negedge clk);
    a_i = 8'h01; b_i = 8'h00; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;                     // E0
    start = 1'b0;
    repeat (4) @(posedge clk);              // E4
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy_e, done_e, lt_e, gt_e, eq_e, busy_f, done_f, lt_f, gt_f, eq_f} !== 10'b0) begin
      bad++;
      $display("FAIL abort_outputs got e=%b%b%b%b%b f=%b%b%b%b%b required all 0",
               busy_e, done_e, lt_e, gt_e, eq_e, busy_f, done_f, lt_f, gt_f, eq_f);
    end
    ndone = 0;
    repeat (2) begin @(posedge clk); #1; if (done_e === 1'b1 || done_f === 1'b1) ndone++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done_e === 1'b1 || done_f === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0 || busy_e !== 1'b0 || busy_f !== 1'b0) begin bad++;
      $display("FAIL abort_no_done dones=%0d busy=%b/%b required 0/0/0", ndone, busy_e, busy_f); end
    run_op(8'h01, 8'h00, 1'b0, le, lf, re, rf, nde, ndf, berr);
    er = exp_res(8'h01, 8'h00, 1'b0);
    total++;
    if (le !== exp_lat(8'h01, 8'h00) || lf !== W || re !== er || rf !== er ||
        nde !== 1 || ndf !== 1 || berr !== 0) begin
      bad++;
      $display("FAIL abort_recover lat=%0d/%0d res=%b/%b dones=%0d/%0d berr=%0d required %0d/%0d %b 1/1 0",
               le, lf, re, rf, nde, ndf, berr, exp_lat(8'h01, 8'h00), W, er);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
